mc_stage_sequencer: RTL and testbench

- Parametrised control FSM for the multi-cycle CPU family. It sequences NSTAGE execution stages (FETCH..WB generalised) one at a time using per-stage "over" handshakes.
- Supports early retire from any stage (branch/jump without link), a flush/abort input, and a debug single-step halt mode.
- Drives stage valids, inter-stage bus-latch enables and the next_fetch PC-update strobe. Keeps wrapping cycle and retire counters for the display/test path.

---
 rtl/mc_pkg.sv | 24 ++
 rtl/mc_stage_sequencer_if.sv | 25 ++
 rtl/mc_perf_counter.sv | 21 ++
 rtl/mc_stage_sequencer.sv | 98 +++++++++
 tb/tb_mc_stage_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared state-code constants for the multi-cycle stage sequencer.
// IDLE is 0, stage k is k+1, HALT follows the last stage.
package mc_pkg;

  localparam int ST_IDLE      = 0;
  localparam int ST_STAGE_OFS = 1;
  localparam int ST_HALT_OFS  = 1;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_STAGE,
    PH_HALT,
    PH_BAD
  } phase_e;

  function automatic int st_code(int k);
    return k + ST_STAGE_OFS;
  endfunction

  function automatic int halt_code(int nstage);
    return nstage + ST_HALT_OFS;
  endfunction

endpackage

// File: rtl/mc_stage_sequencer_if.sv
// Stage handshake bundle: per-stage over/valid, latch enables, fetch strobe.
// master = sequencer, slave = datapath stages.
interface mc_stage_sequencer_if #(
  parameter int NSTAGE = 5
);

  logic [NSTAGE-1:0] stage_over;
  logic              early_retire;
  logic              flush;
  logic [NSTAGE-1:0] stage_valid;
  logic [NSTAGE-2:0] latch_en;
  logic              next_fetch;
  logic              retire;

  modport master (
    input  stage_over, early_retire, flush,
    output stage_valid, latch_en, next_fetch, retire
  );

  modport slave (
    output stage_over, early_retire, flush,
    input  stage_valid, latch_en, next_fetch, retire
  );

endinterface

// File: rtl/mc_perf_counter.sv
// Wrapping enable counter for the display/test path.
// Ports: clk, resetn (sync, low), i_en, o_cnt.
module mc_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mc_stage_sequencer.sv
// Multi-cycle stage sequencer: walks NSTAGE stages on per-stage over,
// with early retire, flush, single-step HALT and perf counters.
// Ports: clk, resetn, bus (stage handshake), step_mode, step,
// state, halted, cycle_cnt, retire_cnt.
module mc_stage_sequencer
  import mc_pkg::*;
#(
  parameter  int NSTAGE = 5,
  parameter  int CNT_W  = 32,
  localparam int ST_W   = $clog2(NSTAGE + 2)
) (
  input  logic                 clk,
  input  logic                 resetn,
  mc_stage_sequencer_if.master bus,
  input  logic                 step_mode,
  input  logic                 step,
  output logic [ST_W-1:0]      state,
  output logic                 halted,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt
);

  localparam logic [ST_W-1:0] C_IDLE = ST_W'(ST_IDLE);
  localparam logic [ST_W-1:0] C_S0   = ST_W'(st_code(0));
  localparam logic [ST_W-1:0] C_SL   = ST_W'(st_code(NSTAGE - 1));
  localparam logic [ST_W-1:0] C_HALT = ST_W'(halt_code(NSTAGE));
  localparam logic [NSTAGE-1:0] C_ONE = {{(NSTAGE-1){1'b0}}, 1'b1};

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_next;
  phase_e            w_phase;
  logic [NSTAGE-1:0] w_valid;
  logic              w_over;
  logic              w_adv;
  logic              w_first;
  logic              w_last;
  logic              w_retire;

  always_comb begin
    w_phase = PH_BAD;
    if (r_state == C_IDLE) w_phase = PH_IDLE;
    else if (r_state >= C_S0 && r_state <= C_SL) w_phase = PH_STAGE;
    else if (r_state == C_HALT) w_phase = PH_HALT;
  end

  assign w_valid  = (w_phase == PH_STAGE) ? (C_ONE << (r_state - C_S0)) : '0;
  assign w_over   = |(w_valid & bus.stage_over);
  assign w_adv    = w_over & ~bus.flush;
  assign w_first  = (r_state == C_S0);
  assign w_last   = (r_state == C_SL);
  // early_retire only counts past fetch
  assign w_retire = w_adv & (w_last | (bus.early_retire & ~w_first));

  always_comb begin
    w_next = C_IDLE;
    unique case (w_phase)
      PH_IDLE:  w_next = C_S0;
      PH_HALT:  w_next = (step | ~step_mode) ? C_S0 : C_HALT;
      PH_STAGE: begin
        if (bus.flush) w_next = C_S0;
        else if (w_retire) w_next = step_mode ? C_HALT : C_S0;
        else if (w_adv) w_next = r_state + 1'b1;
        else w_next = r_state;
      end
      default:  w_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= C_IDLE;
    else r_state <= w_next;
  end

  assign bus.stage_valid = w_valid;
  assign bus.latch_en    = w_valid[NSTAGE-2:0]
                         & bus.stage_over[NSTAGE-2:0]
                         & {(NSTAGE-1){~bus.flush}};
  // strobe only on entry into S0, not while S0 waits
  assign bus.next_fetch  = (w_next == C_S0) & (~w_first | bus.flush);
  assign bus.retire      = w_retire;
  assign halted          = (r_state == C_HALT);
  assign state           = r_state;

  mc_perf_counter #(.CNT_W(CNT_W)) u_cyc (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_phase == PH_STAGE),
    .o_cnt  (cycle_cnt)
  );

  mc_perf_counter #(.CNT_W(CNT_W)) u_ret (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_retire),
    .o_cnt  (retire_cnt)
  );

endmodule

// File: tb/tb_mc_stage_sequencer.sv
// Directed bench for mc_stage_sequencer, NSTAGE=5.
// Instance a uses CNT_W=32, instance b CNT_W=4 for wrap.
module tb_mc_stage_sequencer;

  localparam int NS = 5;
  localparam int SW = $clog2(NS + 2);

  logic clk;
  logic resetn;
  logic [NS-1:0] over;
  logic er;
  logic fl;
  logic step_mode;
  logic step;

  logic [SW-1:0] state_a;
  logic          halted_a;
  logic [31:0]   cyc_a;
  logic [31:0]   ret_a;
  logic [SW-1:0] state_b;
  logic          halted_b;
  logic [3:0]    cyc_b;
  logic [3:0]    ret_b;

  int n_chk;
  int n_fail;

  mc_stage_sequencer_if #(.NSTAGE(NS)) bus_a ();
  mc_stage_sequencer_if #(.NSTAGE(NS)) bus_b ();

  assign bus_a.stage_over   = over;
  assign bus_a.early_retire = er;
  assign bus_a.flush        = fl;
  assign bus_b.stage_over   = over;
  assign bus_b.early_retire = er;
  assign bus_b.flush        = fl;

  mc_stage_sequencer #(.NSTAGE(NS), .CNT_W(32)) dut_a (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_a.master),
    .step_mode  (step_mode),
    .step       (step),
    .state      (state_a),
    .halted     (halted_a),
    .cycle_cnt  (cyc_a),
    .retire_cnt (ret_a)
  );

  mc_stage_sequencer #(.NSTAGE(NS), .CNT_W(4)) dut_b (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus_b.master),
    .step_mode  (step_mode),
    .step       (step),
    .state      (state_b),
    .halted     (halted_b),
    .cycle_cnt  (cyc_b),
    .retire_cnt (ret_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    over = '0;
    er = 1'b0;
    fl = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (state_a !== 3'd0) begin
      $display("FAIL reset_state got %0d want 0", state_a);
      n_fail++;
    end
    n_chk++;
    if (bus_a.stage_valid !== 5'b0 || bus_a.latch_en !== 4'b0) begin
      $display("FAIL reset_valid got %b/%b want 0/0",
               bus_a.stage_valid, bus_a.latch_en);
      n_fail++;
    end
    n_chk++;
    if (bus_a.next_fetch !== 1'b1 || bus_a.retire !== 1'b0
        || halted_a !== 1'b0) begin
      $display("FAIL reset_strobes got nf=%b ret=%b h=%b want 1/0/0",
               bus_a.next_fetch, bus_a.retire, halted_a);
      n_fail++;
    end
    n_chk++;
    if (cyc_a !== 32'd0 || ret_a !== 32'd0) begin
      $display("FAIL reset_cnt got %0d/%0d want 0/0", cyc_a, ret_a);
      n_fail++;
    end
  endtask

  task automatic test_all_over();
    int exp_st;
    do_reset();
    over = 5'h1f;
    for (int i = 0; i < 16; i++) begin
      exp_st = (i == 0) ? 0 : ((i - 1) % 5) + 1;
      #1;
      n_chk++;
      if (state_a !== SW'(exp_st)) begin
        $display("FAIL seq_state[%0d] got %0d want %0d", i, state_a, exp_st);
        n_fail++;
      end
      n_chk++;
      if (bus_a.retire !== (exp_st == 5)) begin
        $display("FAIL seq_retire[%0d] got %b want %b",
                 i, bus_a.retire, exp_st == 5);
        n_fail++;
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (state_a !== 3'd1 || ret_a !== 32'd3 || cyc_a !== 32'd15) begin
      $display("FAIL seq_cnt got st=%0d ret=%0d cyc=%0d want 1/3/15",
               state_a, ret_a, cyc_a);
      n_fail++;
    end
  endtask

  task automatic test_early_retire();
    do_reset();
    @(negedge clk);
    #1;
    over = 5'b00001;
    #1;
    n_chk++;
    if (state_a !== 3'd1 || bus_a.latch_en !== 4'b0001
        || bus_a.next_fetch !== 1'b0) begin
      $display("FAIL er_s0 got st=%0d le=%b nf=%b want 1/0001/0",
               state_a, bus_a.latch_en, bus_a.next_fetch);
      n_fail++;
    end
    @(negedge clk);
    over = 5'b00010;
    er = 1'b1;
    #1;
    n_chk++;
    if (state_a !== 3'd2 || bus_a.retire !== 1'b1
        || bus_a.next_fetch !== 1'b1 || bus_a.latch_en !== 4'b0010) begin
      $display("FAIL er_s1 got st=%0d ret=%b nf=%b le=%b want 2/1/1/0010",
               state_a, bus_a.retire, bus_a.next_fetch, bus_a.latch_en);
      n_fail++;
    end
    @(negedge clk);
    over = 5'b00001;
    er = 1'b1;
    #1;
    n_chk++;
    if (state_a !== 3'd1 || ret_a !== 32'd1 || cyc_a !== 32'd2) begin
      $display("FAIL er_after got st=%0d ret=%0d cyc=%0d want 1/1/2",
               state_a, ret_a, cyc_a);
      n_fail++;
    end
    n_chk++;
    if (bus_a.retire !== 1'b0) begin
      $display("FAIL er_in_s0 got ret=%b want 0", bus_a.retire);
      n_fail++;
    end
    @(negedge clk);
    er = 1'b0;
    over = '0;
    #1;
    n_chk++;
    if (state_a !== 3'd2) begin
      $display("FAIL er_s0_adv got %0d want 2", state_a);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    over = 5'h1f;
    repeat (4) @(negedge clk);
    over = 5'b01000;
    fl = 1'b1;
    #1;
    n_chk++;
    if (state_a !== 3'd4 || bus_a.retire !== 1'b0
        || bus_a.latch_en !== 4'b0000 || bus_a.next_fetch !== 1'b1) begin
      $display("FAIL flush_s3 got st=%0d ret=%b le=%b nf=%b want 4/0/0000/1",
               state_a, bus_a.retire, bus_a.latch_en, bus_a.next_fetch);
      n_fail++;
    end
    @(negedge clk);
    fl = 1'b0;
    over = '0;
    #1;
    n_chk++;
    if (state_a !== 3'd1 || ret_a !== 32'd0 || cyc_a !== 32'd4) begin
      $display("FAIL flush_after got st=%0d ret=%0d cyc=%0d want 1/0/4",
               state_a, ret_a, cyc_a);
      n_fail++;
    end
  endtask

  task automatic test_step();
    do_reset();
    step_mode = 1'b1;
    over = 5'h1f;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (state_a !== 3'd5 || bus_a.retire !== 1'b1 || halted_a !== 1'b0) begin
      $display("FAIL step_ret got st=%0d ret=%b h=%b want 5/1/0",
               state_a, bus_a.retire, halted_a);
      n_fail++;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (state_a !== 3'd6 || cyc_a !== 32'd5 || ret_a !== 32'd1) begin
      $display("FAIL step_halt got st=%0d cyc=%0d ret=%0d want 6/5/1",
               state_a, cyc_a, ret_a);
      n_fail++;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      n_chk++;
      if (halted_a !== 1'b1 || cyc_a !== 32'd5
          || bus_a.next_fetch !== 1'b0) begin
        $display("FAIL step_hold[%0d] got h=%b cyc=%0d nf=%b want 1/5/0",
                 i, halted_a, cyc_a, bus_a.next_fetch);
        n_fail++;
      end
      @(negedge clk);
    end
    step = 1'b1;
    #1;
    n_chk++;
    if (bus_a.next_fetch !== 1'b1) begin
      $display("FAIL step_nf got %b want 1", bus_a.next_fetch);
      n_fail++;
    end
    @(negedge clk);
    step = 1'b0;
    #1;
    n_chk++;
    if (state_a !== 3'd1 || halted_a !== 1'b0) begin
      $display("FAIL step_rel got st=%0d h=%b want 1/0", state_a, halted_a);
      n_fail++;
    end
    repeat (4) @(negedge clk);
    step = 1'b1;
    #1;
    n_chk++;
    if (state_a !== 3'd5 || bus_a.retire !== 1'b1) begin
      $display("FAIL step_sim_ret got st=%0d ret=%b want 5/1",
               state_a, bus_a.retire);
      n_fail++;
    end
    @(negedge clk);
    step = 1'b0;
    #1;
    n_chk++;
    if (state_a !== 3'd6) begin
      $display("FAIL step_sim_halt got %0d want 6", state_a);
      n_fail++;
    end
    step_mode = 1'b0;
    #1;
    n_chk++;
    if (bus_a.next_fetch !== 1'b1) begin
      $display("FAIL step_mode_off_nf got %b want 1", bus_a.next_fetch);
      n_fail++;
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (state_a !== 3'd1 || cyc_a !== 32'd10 || ret_a !== 32'd2) begin
      $display("FAIL step_end got st=%0d cyc=%0d ret=%0d want 1/10/2",
               state_a, cyc_a, ret_a);
      n_fail++;
    end
  endtask

  task automatic test_stall_reset();
    over = 5'b11011;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (state_a !== 3'd3 || cyc_a !== 32'd12 || ret_a !== 32'd2) begin
      $display("FAIL stall_in got st=%0d cyc=%0d ret=%0d want 3/12/2",
               state_a, cyc_a, ret_a);
      n_fail++;
    end
    repeat (7) @(negedge clk);
    #1;
    n_chk++;
    if (state_a !== 3'd3 || cyc_a !== 32'd19) begin
      $display("FAIL stall_hold got st=%0d cyc=%0d want 3/19",
               state_a, cyc_a);
      n_fail++;
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_chk++;
    if (state_a !== 3'd0 || cyc_a !== 32'd0 || ret_a !== 32'd0) begin
      $display("FAIL stall_reset got st=%0d cyc=%0d ret=%0d want 0/0/0",
               state_a, cyc_a, ret_a);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    over = 5'h1f;
    repeat (81) @(negedge clk);
    #1;
    n_chk++;
    if (ret_a !== 32'd16 || cyc_a !== 32'd80) begin
      $display("FAIL wrap_wide got ret=%0d cyc=%0d want 16/80", ret_a, cyc_a);
      n_fail++;
    end
    n_chk++;
    if (ret_b !== 4'd0 || cyc_b !== 4'd0 || state_b !== 3'd1) begin
      $display("FAIL wrap_narrow got ret=%0d cyc=%0d st=%0d want 0/0/1",
               ret_b, cyc_b, state_b);
      n_fail++;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 1'b0;
    over = '0;
    er = 1'b0;
    fl = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    test_reset();
    test_all_over();
    test_early_retire();
    test_flush();
    test_step();
    test_stall_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
